data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Multi-cycle data-memory responder; it is the slave side of the memEn/memWrt request
//   interface driven by the decoder/control path.
// - Accepts one load or store at a time and completes it after a fixed latency.
// - Raises stall to freeze the requesting pipeline, then pulses done with the read data.
// - Sits between the execute-stage address/data and the writeback mux (regWrtSrc = memory).
// PARAMETERS
// - ADDR_W  default 8  word-index bits; array holds 2**ADDR_W 16-bit words, indexed by addr[ADDR_W:1]
// - LAT     default 4  request-accept to done latency in cycles; legal range 1..15
// PORTS
// - clk      in   1   system clock; all state updates on rising edge
// - rst      in   1   synchronous, active-high reset
// - memEn    in   1   request valid; held stable by requester while stall=1
// - memWrt   in   1   1 = store, 0 = load; qualified by memEn
// - halt     in   1   no new request accepted while 1; an in-flight request still completes
// - addr     in   16  byte address; bit 0 = alignment bit; bits above ADDR_W ignored (alias)
// - dataIn   in   16  store data
// - dataOut  out  16  load data; valid only when done=1
// - stall    out  1   request outstanding and not yet complete (combinational)
// - done     out  1   one-cycle completion pulse
// - err      out  1   completion with error; asserted only together with done
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, dataOut=0, done=0, err=0, stall=0. Reset clears all
//   request/latch state and drops any pending store. The memory array is NOT cleared.
// - FSM states: IDLE, BUSY, DONE.
//   - IDLE: if memEn & ~halt, latch memWrt/addr/dataIn, cnt<=LAT-1; next state is BUSY
//     when LAT>1, else DONE. Otherwise stay in IDLE.
//   - BUSY: cnt decrements each cycle; when cnt reaches 1, next state is DONE.
//   - DONE: done=1 for exactly this cycle; next state is IDLE unconditionally.
//   - memEn still high in the cycle after DONE is a NEW request.
// - Latency: request sampled at edge k gives done=1 during cycle k+LAT.
// - stall = (IDLE & memEn & ~halt) | BUSY. stall=0 in DONE.
//   With LAT=1, stall is high only during the accept cycle.
// - Inputs are ignored in BUSY and DONE; execution always uses the latched copies.
// - Store: array[latched addr] <= latched dataIn on the edge that enters DONE; dataOut=0 in DONE.
// - Load: dataOut <= array[latched addr] on the edge that enters DONE, so it reflects all
//   earlier committed stores. dataOut returns to 0 on leaving DONE.
// - Back-to-back store then load to the same word: the load returns the new data.
// - halt & memEn together in IDLE: stall=0, nothing accepted, no done.
// - Reset mid-operation (BUSY or DONE): a store not yet committed is lost; a store already
//   committed is retained.
// - err=0 when the ALIGN_CHK_EN macro (see CONFIGURATION) is undefined.
// CONFIGURATION
// - Macro ALIGN_CHK_EN.
// - Defined: a request with latched addr[0]=1 still runs the full LAT cycles. In DONE:
//   done=1, err=1, dataOut=0, and no array write occurs.
// - Undefined: addr[0] is ignored, err is tied to 0, and an odd address accesses the
//   containing word.
// TESTING (LAT=4, ADDR_W=8)
// - Store 0xBEEF to 0x0010 at edge 0 -> stall=1 in cycles 0..3, done=1 in cycle 4, stall=0;
//   a later load of 0x0010 returns 0xBEEF at done.
// - Store 0x1234 to 0x0020, then a load of 0x0020 issued the cycle after done ->
//   second done 5 cycles after the first, dataOut=0x1234.
// - Load from 0x0210 after a store of 0xAAAA to 0x0010 -> dataOut=0xAAAA (aliasing above ADDR_W).
// - Store 0x5555 to 0x0030, rst pulsed in cycle 2 -> no done; a later load of 0x0030
//   returns the prior contents. Repeat with rst in cycle 5 (after done) -> load returns 0x5555.
// - halt=1 with memEn=1 in IDLE for 3 cycles -> stall=0, done=0. Deassert halt ->
//   normal accept, done 4 cycles later.
// - ALIGN_CHK_EN defined, store 0xFFFF to 0x0041 -> done=1, err=1 in cycle 4; word 0x0040
//   unchanged. Without the macro -> err=0 and word 0x0040 = 0xFFFF.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the pipeline control path (master) and the data-memory
// responder (slave): memEn/memWrt request, byte address, store data, stall/done/err status.
interface data_mem_responder_if;
   logic        memEn;
   logic        memWrt;
   logic        halt;
   logic [15:0] addr;
   logic [15:0] dataIn;
   logic [15:0] dataOut;
   logic        stall;
   logic        done;
   logic        err;

   modport master (
      output memEn, memWrt, halt, addr, dataIn,
      input  dataOut, stall, done, err
   );

   modport slave (
      input  memEn, memWrt, halt, addr, dataIn,
      output dataOut, stall, done, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store, stalls the requester for LAT
// cycles, then pulses done. Optional misaligned-address error checking under `ALIGN_CHK_EN.
module data_mem_responder #(
   parameter int ADDR_W = 8,
   parameter int LAT    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_wrt;
   logic [15:0] r_addr;
   logic [15:0] r_data;
   logic        r_done;
   logic        r_err;
   logic [15:0] r_dout;
   logic [15:0] r_mem [2**ADDR_W];

   logic        w_accept;
   logic        w_enter_done;
   logic        w_op_wrt;
   logic [15:0] w_op_addr;
   logic [15:0] w_op_data;
   logic        w_misal;
   logic        w_we;
   logic [ADDR_W-1:0] w_idx;
   logic        w_unused;

   assign w_accept     = (r_state == IDLE) && bus.memEn && !bus.halt;
   assign w_enter_done = (w_accept && (LAT == 1)) || ((r_state == BUSY) && (r_cnt == 4'd1));

   // With LAT=1 the operation completes on the accept edge, before anything is latched.
   assign w_op_wrt  = (r_state == IDLE) ? bus.memWrt : r_wrt;
   assign w_op_addr = (r_state == IDLE) ? bus.addr   : r_addr;
   assign w_op_data = (r_state == IDLE) ? bus.dataIn : r_data;
   assign w_idx     = w_op_addr[ADDR_W:1];

`ifdef ALIGN_CHK_EN
   assign w_misal = w_op_addr[0];
`else
   assign w_misal = 1'b0;
`endif

   // A store commits only on the edge entering DONE; reset on that edge drops it.
   assign w_we = w_enter_done && w_op_wrt && !w_misal && !rst;

   assign w_unused = ^{w_op_addr[15:ADDR_W+1], w_op_addr[0]};

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_idx] <= w_op_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_wrt   <= 1'b0;
         r_addr  <= 16'd0;
         r_data  <= 16'd0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_dout  <= 16'd0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_dout <= 16'd0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_wrt   <= bus.memWrt;
                  r_addr  <= bus.addr;
                  r_data  <= bus.dataIn;
                  r_cnt   <= 4'(LAT - 1);
                  r_state <= (LAT > 1) ? BUSY : DONE;
               end
            end
            BUSY: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         if (w_enter_done) begin
            r_done <= 1'b1;
            r_err  <= w_misal;
            r_dout <= (!w_op_wrt && !w_misal) ? r_mem[w_idx] : 16'd0;
         end
      end
   end

   assign bus.stall   = w_accept || (r_state == BUSY);
   assign bus.done    = r_done;
   assign bus.err     = r_err;
   assign bus.dataOut = r_dout;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LAT=4, ADDR_W=8); inputs change on the falling
// edge, outputs are sampled on the falling edge (or 1 time unit after a drive).
module tb_data_mem_responder;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   data_mem_responder_if bus ();

   data_mem_responder #(.ADDR_W(8), .LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Drive a request and run until done (bounded). Returns cycles from issue to done,
   // number of cycles with stall high before done, stall in the done cycle, and results.
   task automatic xfer(input logic wrt, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output int st_cycles, output logic st_done,
                       output logic [15:0] rdata, output logic rerr);
      bus.memEn = 1'b1; bus.memWrt = wrt; bus.addr = a; bus.dataIn = d; bus.halt = 1'b0;
      lat = -1; st_cycles = 0; st_done = 1'b0; rdata = 16'd0; rerr = 1'b0;
      #1;
      if (bus.stall) st_cycles++;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = c; rdata = bus.dataOut; rerr = bus.err; st_done = bus.stall;
            break;
         end
         if (bus.stall) st_cycles++;
      end
      $display("xfer wrt=%0b addr=%h din=%h -> lat=%0d stall_cycles=%0d dout=%h err=%0b",
               wrt, a, d, lat, st_cycles, rdata, rerr);
   endtask

   task automatic release_bus();
      bus.memEn = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.memEn = 1'b0; bus.memWrt = 1'b0; bus.halt = 1'b0;
      bus.addr = 16'd0; bus.dataIn = 16'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.stall, bus.done, bus.err, bus.dataOut} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got stall=%b done=%b err=%b dout=%h, want all 0",
                  bus.stall, bus.done, bus.err, bus.dataOut);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_store_load();
      int lat, stc; logic sd, e; logic [15:0] rd;
      xfer(1'b1, 16'h0010, 16'hBEEF, lat, stc, sd, rd, e);
      n_checks++;
      if (lat !== 4 || stc !== 4 || sd !== 1'b0) begin
         n_fail++;
         $display("FAIL store_timing: got lat=%0d stall_cycles=%0d stall_at_done=%b, want 4 4 0", lat, stc, sd);
      end
      n_checks++;
      if (rd !== 16'd0 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL store_dout: got dout=%h err=%b, want 0000 0", rd, e);
      end
      release_bus();
      n_checks++;
      if (bus.done !== 1'b0 || bus.dataOut !== 16'd0) begin
         n_fail++;
         $display("FAIL done_pulse: got done=%b dout=%h after DONE, want 0 0000", bus.done, bus.dataOut);
      end
      xfer(1'b0, 16'h0010, 16'h0000, lat, stc, sd, rd, e);
      n_checks++;
      if (lat !== 4 || rd !== 16'hBEEF || e !== 1'b0) begin
         n_fail++;
         $display("FAIL load_beef: got lat=%0d dout=%h err=%b, want 4 beef 0", lat, rd, e);
      end
      release_bus();
      n_checks++;
      if (bus.dataOut !== 16'd0) begin
         n_fail++;
         $display("FAIL dout_clear: got dout=%h after DONE, want 0000", bus.dataOut);
      end
   endtask

   task automatic test_back_to_back();
      int lat, stc; logic sd, e; logic [15:0] rd;
      xfer(1'b1, 16'h0020, 16'h1234, lat, stc, sd, rd, e);
      // Load request presented during the DONE cycle: not accepted until the IDLE cycle after.
      xfer(1'b0, 16'h0020, 16'h0000, lat, stc, sd, rd, e);
      n_checks++;
      if (lat !== 5 || stc !== 4 || rd !== 16'h1234) begin
         n_fail++;
         $display("FAIL back_to_back: got lat=%0d stall_cycles=%0d dout=%h, want 5 4 1234", lat, stc, rd);
      end
      release_bus();
   endtask

   task automatic test_alias();
      int lat, stc; logic sd, e; logic [15:0] rd;
      xfer(1'b1, 16'h0010, 16'hAAAA, lat, stc, sd, rd, e);
      release_bus();
      xfer(1'b0, 16'h0210, 16'h0000, lat, stc, sd, rd, e);
      n_checks++;
      if (rd !== 16'hAAAA) begin
         n_fail++;
         $display("FAIL alias_load: got dout=%h, want aaaa", rd);
      end
      release_bus();
   endtask

   task automatic test_reset_mid_op();
      int lat, stc, nd; logic sd, e; logic [15:0] rd;
      xfer(1'b1, 16'h0030, 16'h1111, lat, stc, sd, rd, e);
      release_bus();
      bus.memEn = 1'b1; bus.memWrt = 1'b1; bus.addr = 16'h0030; bus.dataIn = 16'h5555;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus.memEn = 1'b0;
      #1;
      n_checks++;
      if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.dataOut !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_busy_state: got stall=%b done=%b dout=%h, want 0 0 0000",
                  bus.stall, bus.done, bus.dataOut);
      end
      nd = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      n_checks++;
      if (nd !== 0) begin
         n_fail++;
         $display("FAIL rst_busy_nodone: got %0d done pulses, want 0", nd);
      end
      xfer(1'b0, 16'h0030, 16'h0000, lat, stc, sd, rd, e);
      n_checks++;
      if (rd !== 16'h1111) begin
         n_fail++;
         $display("FAIL rst_busy_lost: got dout=%h, want 1111", rd);
      end
      release_bus();
      xfer(1'b1, 16'h0030, 16'h5555, lat, stc, sd, rd, e);
      bus.memEn = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xfer(1'b0, 16'h0030, 16'h0000, lat, stc, sd, rd, e);
      n_checks++;
      if (rd !== 16'h5555) begin
         n_fail++;
         $display("FAIL rst_after_done: got dout=%h, want 5555", rd);
      end
      release_bus();
   endtask

   task automatic test_halt();
      int lat, stc, bad; logic sd, e; logic [15:0] rd;
      bus.memEn = 1'b1; bus.memWrt = 1'b0; bus.addr = 16'h0010; bus.halt = 1'b1;
      bad = 0;
      repeat (3) begin
         #1;
         if (bus.stall !== 1'b0) bad++;
         @(negedge clk);
         if (bus.done !== 1'b0) bad++;
      end
      $display("halt held 3 cycles: violations=%0d", bad);
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL halt_block: got %0d stall/done assertions, want 0", bad);
      end
      xfer(1'b0, 16'h0010, 16'h0000, lat, stc, sd, rd, e);
      n_checks++;
      if (lat !== 4 || rd !== 16'hAAAA) begin
         n_fail++;
         $display("FAIL halt_release: got lat=%0d dout=%h, want 4 aaaa", lat, rd);
      end
      release_bus();
   endtask

   task automatic test_align();
      int lat, stc; logic sd, e; logic [15:0] rd;
      xfer(1'b1, 16'h0040, 16'h0F0F, lat, stc, sd, rd, e);
      release_bus();
      xfer(1'b1, 16'h0041, 16'hFFFF, lat, stc, sd, rd, e);
`ifdef ALIGN_CHK_EN
      n_checks++;
      if (lat !== 4 || e !== 1'b1 || rd !== 16'd0) begin
         n_fail++;
         $display("FAIL misal_store: got lat=%0d err=%b dout=%h, want 4 1 0000", lat, e, rd);
      end
`else
      n_checks++;
      if (lat !== 4 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL odd_store: got lat=%0d err=%b, want 4 0", lat, e);
      end
`endif
      release_bus();
      xfer(1'b0, 16'h0040, 16'h0000, lat, stc, sd, rd, e);
`ifdef ALIGN_CHK_EN
      n_checks++;
      if (rd !== 16'h0F0F || e !== 1'b0) begin
         n_fail++;
         $display("FAIL misal_nowrite: got dout=%h err=%b, want 0f0f 0", rd, e);
      end
`else
      n_checks++;
      if (rd !== 16'hFFFF || e !== 1'b0) begin
         n_fail++;
         $display("FAIL odd_word: got dout=%h err=%b, want ffff 0", rd, e);
      end
`endif
      release_bus();
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_back_to_back();
      test_alias();
      test_reset_mid_op();
      test_halt();
      test_align();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
